// File: rtl/branch_predictor_gshare_pkg.sv
// Shared types and default sizing for the LC-3b direction predictor.
package branch_predictor_gshare_pkg;

  localparam int BP_INDEX_BITS = 5;
  localparam int BP_CTR_BITS   = 2;
  localparam int BP_HIST_BITS  = 5;

  typedef logic [15:0]              lc3b_word;
  typedef logic [BP_INDEX_BITS-1:0] lc3b_p_index;

  typedef enum logic {
    BP_INIT,
    BP_READY
  } bp_state_t;

endpackage

// File: rtl/branch_predictor_gshare_if.sv
// Fetch-lookup and execute-retire signals between the pipeline and the predictor.
interface branch_predictor_gshare_if
  import branch_predictor_gshare_pkg::*;
#(
  parameter int INDEX_BITS = BP_INDEX_BITS,
  parameter int HIST_BITS  = BP_HIST_BITS
) ();

  lc3b_word              pred_pc;
  logic                  pred_valid;
  logic                  pred_ready;
  logic                  pred_taken;
  logic [INDEX_BITS-1:0] pred_index;
  logic [HIST_BITS-1:0]  pred_hist;

  logic                  upd_valid;
  logic [INDEX_BITS-1:0] upd_index;
  logic [HIST_BITS-1:0]  upd_hist;
  logic                  upd_taken;
  logic                  upd_mispred;

  modport master (
    output pred_pc, pred_valid, upd_valid, upd_index, upd_hist, upd_taken, upd_mispred,
    input  pred_ready, pred_taken, pred_index, pred_hist
  );

  modport slave (
    input  pred_pc, pred_valid, upd_valid, upd_index, upd_hist, upd_taken, upd_mispred,
    output pred_ready, pred_taken, pred_index, pred_hist
  );

endinterface

// File: rtl/branch_predictor_gshare_sat_counter.sv
// Saturating up/down counter step used on the predictor update path.
module bp_sat_counter #(
  parameter int W = 2
) (
  input  logic [W-1:0] ctr,
  input  logic         taken,
  output logic [W-1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != {W{1'b1}}) ctr_next = ctr + W'(1);
    end else begin
      if (ctr != '0) ctr_next = ctr - W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Gshare/bimodal direction predictor: init sweep, zero-latency lookup,
// speculative global history with mispredict recovery.
module branch_predictor_gshare
  import branch_predictor_gshare_pkg::*;
#(
  parameter int INDEX_BITS = BP_INDEX_BITS,
  parameter int CTR_BITS   = BP_CTR_BITS,
  parameter int HIST_BITS  = BP_HIST_BITS,
  parameter bit USE_GSHARE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  branch_predictor_gshare_if.slave bp
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

  bp_state_t             r_state;
  logic                  r_ready;
  logic [INDEX_BITS-1:0] r_init_ptr;
  logic [HIST_BITS-1:0]  r_ghr;
  logic [CTR_BITS-1:0]   r_table [DEPTH];

  logic [INDEX_BITS-1:0] w_pc_idx;
  logic [INDEX_BITS-1:0] w_lookup;
  logic                  w_pred_taken;
  logic [CTR_BITS-1:0]   w_ctr_next;

  assign w_pc_idx     = bp.pred_pc[INDEX_BITS:1];
  assign w_lookup     = USE_GSHARE ? (w_pc_idx ^ INDEX_BITS'(r_ghr)) : w_pc_idx;
  assign w_pred_taken = r_table[w_lookup][CTR_BITS-1];

  // Outputs are forced quiet until the sweep has initialised every entry.
  assign bp.pred_ready = r_ready;
  assign bp.pred_taken = r_ready & w_pred_taken;
  assign bp.pred_index = r_ready ? w_lookup : '0;
  assign bp.pred_hist  = r_ready ? r_ghr : '0;

  bp_sat_counter #(.W(CTR_BITS)) u_sat_counter (
    .ctr      (r_table[bp.upd_index]),
    .taken    (bp.upd_taken),
    .ctr_next (w_ctr_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= BP_INIT;
      r_ready    <= 1'b0;
      r_init_ptr <= '0;
      r_ghr      <= '0;
    end else begin
      case (r_state)
        BP_INIT: begin
          r_init_ptr <= r_init_ptr + INDEX_BITS'(1);
          if (&r_init_ptr) begin
            r_state <= BP_READY;
            r_ready <= 1'b1;
          end
        end
        BP_READY: begin
          if (bp.upd_valid && bp.upd_mispred)
            r_ghr <= {bp.upd_hist[HIST_BITS-2:0], bp.upd_taken};
          else if (bp.pred_valid)
            r_ghr <= {r_ghr[HIST_BITS-2:0], w_pred_taken};
        end
        default: begin
          r_state <= BP_INIT;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Table write port: sweep while initialising, retiring branch otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == BP_INIT)
        r_table[r_init_ptr] <= CTR_WEAK;
      else if (bp.upd_valid)
        r_table[bp.upd_index] <= w_ctr_next;
    end
  end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench: one bimodal and one gshare instance sharing clk/rst.
module tb_branch_predictor_gshare;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n;

  always #5 clk = ~clk;

  branch_predictor_gshare_if bi ();
  branch_predictor_gshare_if gi ();

  branch_predictor_gshare #(.USE_GSHARE(1'b0)) u_bim (.clk(clk), .rst(rst), .bp(bi));
  branch_predictor_gshare #(.USE_GSHARE(1'b1)) u_gsh (.clk(clk), .rst(rst), .bp(gi));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!bi.pred_ready && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic bim_upd(input logic taken, input logic exp_taken, input string tag);
    bi.upd_valid = 1'b1;
    bi.upd_index = 5'd4;
    bi.upd_taken = taken;
    @(negedge clk);
    bi.upd_valid = 1'b0;
    #1;
    check(tag, bi.pred_taken, exp_taken);
  endtask

  initial begin
    bi.pred_pc = '0; bi.pred_valid = 0; bi.upd_valid = 0; bi.upd_index = '0;
    bi.upd_hist = '0; bi.upd_taken = 0; bi.upd_mispred = 0;
    gi.pred_pc = '0; gi.pred_valid = 0; gi.upd_valid = 0; gi.upd_index = '0;
    gi.upd_hist = '0; gi.upd_taken = 0; gi.upd_mispred = 0;

    // 1: reset, sweep length, quiet outputs during INIT, all entries weakly taken
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    gi.pred_pc = 16'h0008;
    #1;
    check("init_taken_zero", gi.pred_taken, 1'b0);
    check("init_index_zero", gi.pred_index, 5'd0);
    wait_ready(n);
    check("sweep_len", n, 32);
    check("gsh_ready", gi.pred_ready, 1'b1);
    for (int i = 0; i < 32; i++) begin
      bi.pred_pc = 16'(i << 1);
      gi.pred_pc = 16'(i << 1);
      #1;
      check("bim_init_taken", bi.pred_taken, 1'b1);
      check("bim_index", bi.pred_index, 32'(i));
      check("gsh_init_taken", gi.pred_taken, 1'b1);
    end
    check("hist_reset", gi.pred_hist, 5'd0);

    // 2: bimodal saturating counter at index 4
    bi.pred_pc = 16'h0008;
    @(negedge clk);
    bim_upd(1'b1, 1'b1, "bim_t1_11");
    bim_upd(1'b1, 1'b1, "bim_t2_11");
    bim_upd(1'b1, 1'b1, "bim_t3_sat11");
    bim_upd(1'b0, 1'b1, "bim_n1_10");
    bim_upd(1'b0, 1'b0, "bim_n2_01");
    bim_upd(1'b0, 1'b0, "bim_n3_00");
    bim_upd(1'b0, 1'b0, "bim_n4_sat00");
    bim_upd(1'b1, 1'b0, "bim_t_01");
    bim_upd(1'b1, 1'b1, "bim_t_10");
    check("bim_hist_idle", bi.pred_hist, 5'd0);

    // 3: gshare history build-up to 00011, then index 4^3 = 7
    gi.pred_pc = 16'h0000;
    gi.pred_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    gi.pred_valid = 1'b0;
    gi.pred_pc = 16'h0008;
    #1;
    check("gsh_hist_00011", gi.pred_hist, 5'b00011);
    check("gsh_index_7", gi.pred_index, 5'd7);
    check("gsh_taken_7", gi.pred_taken, 1'b1);
    gi.pred_valid = 1'b1;
    @(negedge clk);
    gi.pred_valid = 1'b0;
    #1;
    check("gsh_hist_00111", gi.pred_hist, 5'b00111);

    // 4: recovery beats a same-cycle fetch shift; update hits index 20
    gi.upd_valid = 1'b1; gi.upd_mispred = 1'b1; gi.upd_hist = 5'b10101;
    gi.upd_taken = 1'b0; gi.upd_index = 5'd20; gi.pred_valid = 1'b1;
    @(negedge clk);
    gi.upd_valid = 1'b0; gi.upd_mispred = 1'b0; gi.pred_valid = 1'b0;
    #1;
    check("recover_hist", gi.pred_hist, 5'b01010);
    gi.pred_pc = 16'h003C;
    #1;
    check("recover_idx20", gi.pred_index, 5'd20);
    check("recover_ctr20", gi.pred_taken, 1'b0);
    gi.upd_mispred = 1'b1; gi.upd_hist = 5'b11111;
    @(negedge clk);
    gi.upd_mispred = 1'b0;
    #1;
    check("mispred_unqualified", gi.pred_hist, 5'b01010);

    // 5: collision at index 9 (ghr 01010, pc_idx 3)
    gi.upd_valid = 1'b1; gi.upd_index = 5'd9; gi.upd_taken = 1'b0;
    @(negedge clk);
    gi.pred_pc = 16'h0006;
    gi.upd_taken = 1'b1;
    #1;
    check("coll_index", gi.pred_index, 5'd9);
    check("coll_old_value", gi.pred_taken, 1'b0);
    @(negedge clk);
    gi.upd_valid = 1'b0;
    #1;
    check("coll_new_value", gi.pred_taken, 1'b1);

    // 6: reset at init_ptr=17, updates during INIT are ignored
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bi.upd_valid = 1'b1; bi.upd_index = 5'd4; bi.upd_taken = 1'b0;
    gi.upd_valid = 1'b1; gi.upd_index = 5'd0; gi.upd_taken = 1'b1;
    gi.upd_mispred = 1'b1; gi.upd_hist = 5'b11111;
    repeat (17) @(negedge clk);
    check("mid_sweep_not_ready", bi.pred_ready, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_ready(n);
    check("restart_sweep_len", n, 32);
    bi.upd_valid = 1'b0;
    gi.upd_valid = 1'b0; gi.upd_mispred = 1'b0;
    bi.pred_pc = 16'h0008;
    gi.pred_pc = 16'h0000;
    #1;
    check("init_upd_ignored_bim", bi.pred_taken, 1'b1);
    check("init_hist_untouched", gi.pred_hist, 5'd0);
    check("init_upd_ignored_gsh", gi.pred_taken, 1'b1);
    bi.pred_pc = 16'h0028;
    #1;
    check("restart_entry20", bi.pred_taken, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
